// File: rtl/net_config.sv
// Shared types and constants for the net_loader host driver.
package net_config;

    localparam int NET_MEM_BYTES = 945;
    localparam int DATA_W        = 8;
    localparam int IDX_W         = 4;
    localparam int PIX_CNT_W     = $clog2(NET_MEM_BYTES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_RESULT
    } loader_state_t;

endpackage

// File: rtl/net_loader_if.sv
// Pixel stream, net_proc memory/handshake and result port of net_loader.
interface net_loader_if;
    import net_config::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              mem_rst;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              net_start;
    logic              net_done;
    logic [IDX_W-1:0]  net_idx;
    logic              res_valid;
    logic              res_ready;
    logic [IDX_W-1:0]  res_idx;
    logic              res_err;
    logic              busy;

    modport master (
        input  s_valid, s_data, net_done, net_idx, res_ready,
        output s_ready, mem_rst, mem_we, mem_wdata, net_start,
               res_valid, res_idx, res_err, busy
    );

    modport slave (
        output s_valid, s_data, net_done, net_idx, res_ready,
        input  s_ready, mem_rst, mem_we, mem_wdata, net_start,
               res_valid, res_idx, res_err, busy
    );

endinterface

// File: rtl/net_wdog.sv
// Loadable down-counter; expired is high while the count sits at zero.
module net_wdog #(
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/net_loader.sv
// Host driver: clears net_proc memory, streams one image in, starts the net, returns the class.
// Optional WAIT watchdog is compiled in with NET_LOADER_TIMEOUT_EN.
module net_loader
    import net_config::*;
#(
    parameter int NUM_BYTES      = 784,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input logic          clk,
    input logic          rst_n,
    net_loader_if.master bus
);

    if (NUM_BYTES < 1 || NUM_BYTES > NET_MEM_BYTES) begin : g_bad_num_bytes
        $error("net_loader: NUM_BYTES must lie in 1..NET_MEM_BYTES");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("net_loader: TIMEOUT_CYCLES must be at least 2");
    end

    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(NUM_BYTES - 1);

    loader_state_t          state, next_state;
    logic [PIX_CNT_W-1:0]   cnt, cnt_next;
    logic                   first_wait;
    logic                   beat, done_ok, to_hit;
    logic                   s_ready_q, mem_rst_q, mem_we_q, net_start_q;
    logic                   res_valid_q, busy_q;
    logic [DATA_W-1:0]      mem_wdata_q;
    logic [IDX_W-1:0]       res_idx_q;
    logic                   expired;

`ifdef NET_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic res_err_q;

    // Armed while in START so the count begins with the first WAIT cycle.
    net_wdog #(.CNT_W(TO_W)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_START),
        .en       (state == ST_WAIT),
        .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err_q <= 1'b0;
        end else if (done_ok) begin
            res_err_q <= 1'b0;
        end else if (to_hit) begin
            res_err_q <= 1'b1;
        end
    end

    assign bus.res_err = res_err_q;
`else
    assign expired     = 1'b0;
    assign bus.res_err = 1'b0;
`endif

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        beat       = 1'b0;
        done_ok    = 1'b0;
        to_hit     = 1'b0;
        case (state)
            ST_IDLE:   if (bus.s_valid) next_state = ST_CLEAR;
            ST_CLEAR: begin
                cnt_next   = '0;
                next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.s_valid && s_ready_q) begin
                    beat     = 1'b1;
                    cnt_next = cnt + PIX_CNT_W'(1);
                    if (cnt == LAST_PIX) next_state = ST_START;
                end
            end
            ST_START:  next_state = ST_WAIT;
            ST_WAIT: begin
                // A done still high from the previous job is masked for one cycle.
                if (!first_wait) begin
                    if (bus.net_done) begin
                        done_ok    = 1'b1;
                        next_state = ST_RESULT;
                    end else if (expired) begin
                        to_hit     = 1'b1;
                        next_state = ST_RESULT;
                    end
                end
            end
            ST_RESULT: if (bus.res_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            first_wait  <= 1'b0;
            s_ready_q   <= 1'b0;
            mem_rst_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            net_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            first_wait  <= (state == ST_START);
            s_ready_q   <= (next_state == ST_LOAD);
            mem_rst_q   <= (next_state == ST_CLEAR);
            mem_we_q    <= beat;
            net_start_q <= (next_state == ST_START);
            res_valid_q <= (next_state == ST_RESULT);
            busy_q      <= (next_state != ST_IDLE);
            if (beat) mem_wdata_q <= bus.s_data;
            if (done_ok) begin
                res_idx_q <= bus.net_idx;
            end else if (to_hit) begin
                res_idx_q <= 4'hF;
            end
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mem_rst   = mem_rst_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.net_start = net_start_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.busy      = busy_q;

endmodule
